// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers, a registered read port,
// occupancy level and sticky overflow/underflow flags.
module sync_byte_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     clear_n,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     wrreq,
  output logic                     wrfull,
  output logic                     wrempty,
  input  logic                     rdreq,
  output logic [DATA_WIDTH-1:0]    q,
  output logic                     rdempty,
  output logic                     rdfull,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDRESS_WIDTH:0] wptr_reg, wptr_next;
  logic [ADDRESS_WIDTH:0] rptr_reg, rptr_next;
  logic [DATA_WIDTH-1:0]  q_reg;
  logic                   overflow_reg, underflow_reg;
  logic                   full, empty, wr_en, rd_en;

  // Equal pointers mean empty; same slot on opposite laps means full.
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[ADDRESS_WIDTH-1:0] == rptr_reg[ADDRESS_WIDTH-1:0]) &&
                 (wptr_reg[ADDRESS_WIDTH] != rptr_reg[ADDRESS_WIDTH]);

  // Blocking decisions use pre-edge flags only.
  assign wr_en = wrreq & ~full;
  assign rd_en = rdreq & ~empty;

  assign wptr_next = wr_en ? (wptr_reg + PTR_ONE) : wptr_reg;
  assign rptr_next = rd_en ? (rptr_reg + PTR_ONE) : rptr_reg;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (clear_n && wr_en) begin
      mem[wptr_reg[ADDRESS_WIDTH-1:0]] <= data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      q_reg         <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      if (rd_en) begin
        q_reg <= mem[rptr_reg[ADDRESS_WIDTH-1:0]];
      end
      if (wrreq && full) begin
        overflow_reg <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign q         = q_reg;
  assign wrfull    = full;
  assign rdfull    = full;
  assign wrempty   = empty;
  assign rdempty   = empty;
  assign level     = wptr_reg - rptr_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_byte_fifo.sv
// Scoreboard bench for sync_byte_fifo: a queue-based model predicts each
// accepted read and all flags; a negedge monitor compares the DUT to it.
module tb_sync_byte_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          clear_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic          wrfull, wrempty, rdempty, rdfull, overflow, underflow;
  logic [DW-1:0] q;
  logic [AW:0]   level;

  sync_byte_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk_i    (clk_i),
    .clear_n  (clear_n),
    .data     (data),
    .wrreq    (wrreq),
    .wrfull   (wrfull),
    .wrempty  (wrempty),
    .rdreq    (rdreq),
    .q        (q),
    .rdempty  (rdempty),
    .rdfull   (rdfull),
    .level    (level),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held_q = '0;
  bit            model_ovf = 1'b0;
  bit            model_unf = 1'b0;
  bit            rd_fire = 1'b0;
  bit            mon_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: updates from the inputs sampled at each rising edge.
  always @(posedge clk_i) begin
    bit was_full, was_empty;
    rd_fire = 1'b0;
    if (!clear_n) begin
      model_q.delete();
      exp_q.delete();
      held_q    = '0;
      model_ovf = 1'b0;
      model_unf = 1'b0;
      mon_en    = 1'b1;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (rdreq) begin
        if (was_empty) model_unf = 1'b1;
        else begin
          exp_q.push_back(model_q.pop_front());
          rd_fire = 1'b1;
        end
      end
      if (wrreq) begin
        if (was_full) model_ovf = 1'b1;
        else model_q.push_back(data);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a read was accepted.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL q_scoreboard: got %0h expected nothing queued at %0t", q, $time);
        end else begin
          held_q = exp_q.pop_front();
          chk("q_read", {24'd0, q}, {24'd0, held_q});
        end
        rd_fire = 1'b0;
      end else begin
        chk("q_hold", {24'd0, q}, {24'd0, held_q});
      end
      chk("level",     {27'd0, level},     model_q.size());
      chk("rdempty",   {31'd0, rdempty},   {31'd0, model_q.size() == 0});
      chk("wrempty",   {31'd0, wrempty},   {31'd0, model_q.size() == 0});
      chk("wrfull",    {31'd0, wrfull},    {31'd0, model_q.size() == DEPTH});
      chk("rdfull",    {31'd0, rdfull},    {31'd0, model_q.size() == DEPTH});
      chk("overflow",  {31'd0, overflow},  {31'd0, model_ovf});
      chk("underflow", {31'd0, underflow}, {31'd0, model_unf});
    end
  end

  // One transaction per call: inputs change on the falling edge.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic rst_n);
    @(negedge clk_i);
    wrreq   = w;
    rdreq   = r;
    data    = d;
    clear_n = rst_n;
    $display("txn t=%0t clear_n=%0b wrreq=%0b rdreq=%0b data=%02h level_model=%0d",
             $time, rst_n, w, r, d, model_q.size());
  endtask

  initial begin
    // Reset held for two edges, then idle
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Single write / read
    cyc(1, 0, 8'hA5, 1);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'(i), 1);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'hFF, 1);
    cyc(1, 1, 8'hFE, 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Underflow from empty, also with a simultaneous write
    cyc(0, 1, 8'h00, 1);
    cyc(1, 1, 8'h77, 1);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Wrap-around with steady level 3
    for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'h40 + i), 1);
    for (int i = 0; i < 40; i++) cyc(1, 1, DW'(8'h43 + i), 1);
    cyc(0, 0, 8'h00, 1);

    // Mid-operation reset at level 5 with both requests active
    for (int i = 0; i < 5 - 3; i++) cyc(1, 0, DW'(8'h90 + i), 1);
    cyc(1, 1, 8'h55, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h3C, 1);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
          DW'($urandom), ($urandom_range(0, 199) != 0));
    end
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
